vx_issue_sched: RTL and testbench



---
 rtl/vx_issue_sched_pkg.sv | 22 ++
 rtl/vx_issue_sched_if.sv | 37 +++
 rtl/vx_issue_sched_rr_select.sv | 28 ++
 rtl/vx_issue_sched.sv | 137 +++++++++++++
 tb/tb_vx_issue_sched.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/vx_issue_sched_pkg.sv
// Shared definitions for the issue scheduler: width derivations and the
// scoreboard bit index {wid, rd}.
package vx_issue_sched_pkg;

  // Warp-ID width; never narrower than one bit so a single-warp build still has a port.
  function automatic int unsigned calc_nw_bits(input int unsigned n);
    return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
  endfunction

  // Register-index width.
  function automatic int unsigned calc_nr_bits(input int unsigned n);
    return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
  endfunction

  // Flat scoreboard index: warp ID in the upper bits, register number below.
  function automatic int unsigned sb_index(input int unsigned wid,
                                           input int unsigned rd,
                                           input int unsigned nr_bits);
    return (wid << nr_bits) | rd;
  endfunction

endpackage

// File: rtl/vx_issue_sched_if.sv
// Bundle of the buffer-head, dispatch, writeback and perf signals of the
// issue scheduler. The master side is the scheduler itself.
interface vx_issue_sched_if #(
  parameter int NUM_WARPS = 4,
  parameter int NUM_REGS  = 64
);
  localparam int NW_BITS = int'(vx_issue_sched_pkg::calc_nw_bits(NUM_WARPS));
  localparam int NR_BITS = int'(vx_issue_sched_pkg::calc_nr_bits(NUM_REGS));

  logic [NUM_WARPS-1:0]         head_valid;
  logic [NUM_WARPS-1:0]         head_ready;
  logic [NUM_WARPS*NR_BITS-1:0] head_rd;
  logic [NUM_WARPS-1:0]         head_wb;
  logic [NUM_WARPS*NR_BITS-1:0] head_rs1;
  logic [NUM_WARPS*NR_BITS-1:0] head_rs2;
  logic [NUM_WARPS*NR_BITS-1:0] head_rs3;
  logic [NUM_WARPS*3-1:0]       head_use_rs;
  logic                         issue_valid;
  logic [NW_BITS-1:0]           issue_wid;
  logic                         issue_ready;
  logic                         wb_valid;
  logic [NW_BITS-1:0]           wb_wid;
  logic [NR_BITS-1:0]           wb_rd;
  logic [31:0]                  perf_stalls;

  modport master (
    input  head_valid, head_rd, head_wb, head_rs1, head_rs2, head_rs3, head_use_rs,
    input  issue_ready, wb_valid, wb_wid, wb_rd,
    output head_ready, issue_valid, issue_wid, perf_stalls
  );

  modport slave (
    output head_valid, head_rd, head_wb, head_rs1, head_rs2, head_rs3, head_use_rs,
    output issue_ready, wb_valid, wb_wid, wb_rd,
    input  head_ready, issue_valid, issue_wid, perf_stalls
  );
endinterface

// File: rtl/vx_issue_sched_rr_select.sv
// N-way round-robin find-first: the first requester at or after start_i
// (wrapping) gets a one-hot grant. Shared with the writeback arbiter.
module VX_rr_select #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] start_i,
  output logic [N-1:0] grant_o,
  output logic         valid_o
);

  // Scan offsets 0..N-1 from the start pointer; the first hit wins.
  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!valid_o && req_i[j] && (j == ((int'(start_i) + i) % N))) begin
          grant_o[j] = 1'b1;
          valid_o    = 1'b1;
        end else begin
        end
      end
    end
  end

endmodule

// File: rtl/vx_issue_sched.sv
// Per-core issue scheduler: picks one hazard-free warp head per cycle in
// round-robin order, owns the register scoreboard, and registers the winning
// warp ID toward dispatch.
module vx_issue_sched
  import vx_issue_sched_pkg::*;
#(
  parameter int NUM_WARPS = 4,
  parameter int NUM_REGS  = 64
) (
  input logic             clk,
  input logic             reset,
  vx_issue_sched_if.master bus
);
  localparam int NW_BITS  = int'(calc_nw_bits(NUM_WARPS));
  localparam int NR_BITS  = int'(calc_nr_bits(NUM_REGS));
  localparam int SB_IDX_W = NW_BITS + NR_BITS;
  localparam int SB_SIZE  = 1 << SB_IDX_W;

  logic [SB_SIZE-1:0]   sb_q, sb_d;
  logic                 issue_valid_q, issue_valid_d;
  logic [NW_BITS-1:0]   issue_wid_q, issue_wid_d;
  logic [NW_BITS-1:0]   rr_ptr_q, rr_ptr_d;
  logic [31:0]          perf_stalls_q, perf_stalls_d;

  logic [NUM_WARPS-1:0] elig_s;
  logic [NUM_WARPS-1:0] grant_s;
  logic                 any_elig_s;
  logic                 free_s;
  logic [NUM_WARPS-1:0] head_ready_s;
  logic [NW_BITS-1:0]   grant_idx_s;
  logic [NW_BITS-1:0]   next_ptr_s;
  logic [NR_BITS-1:0]   grant_rd_s;
  logic                 grant_wb_s;

  function automatic logic [SB_IDX_W-1:0] sb_idx(input int unsigned wid,
                                                 input logic [NR_BITS-1:0] rd);
    return SB_IDX_W'(sb_index(wid, 32'(rd), NR_BITS));
  endfunction

  assign free_s = !issue_valid_q || bus.issue_ready;

  // A warp is eligible when its head is present and neither a used source
  // nor (for writing heads) the destination is pending in the registered scoreboard.
  always_comb begin
    elig_s = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      elig_s[w] = bus.head_valid[w]
        & ~(bus.head_use_rs[w*3+0] & sb_q[sb_idx(w, bus.head_rs1[w*NR_BITS +: NR_BITS])])
        & ~(bus.head_use_rs[w*3+1] & sb_q[sb_idx(w, bus.head_rs2[w*NR_BITS +: NR_BITS])])
        & ~(bus.head_use_rs[w*3+2] & sb_q[sb_idx(w, bus.head_rs3[w*NR_BITS +: NR_BITS])])
        & ~(bus.head_wb[w]         & sb_q[sb_idx(w, bus.head_rd[w*NR_BITS +: NR_BITS])]);
    end
  end

  VX_rr_select #(
    .N (NUM_WARPS),
    .W (NW_BITS)
  ) u_rr_select (
    .req_i   (elig_s),
    .start_i (rr_ptr_q),
    .grant_o (grant_s),
    .valid_o (any_elig_s)
  );

  // Decode the one-hot grant into an index, the following pointer and the winner's rd/wb.
  always_comb begin
    grant_idx_s = '0;
    next_ptr_s  = '0;
    grant_rd_s  = '0;
    grant_wb_s  = 1'b0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (grant_s[w]) begin
        grant_idx_s = NW_BITS'(w);
        next_ptr_s  = NW_BITS'((w + 1) % NUM_WARPS);
        grant_rd_s  = bus.head_rd[w*NR_BITS +: NR_BITS];
        grant_wb_s  = bus.head_wb[w];
      end else begin
      end
    end
  end

  // Next state: writeback clear first so a same-cycle issue set on the same bit wins.
  always_comb begin
    sb_d          = sb_q;
    issue_valid_d = issue_valid_q;
    issue_wid_d   = issue_wid_q;
    rr_ptr_d      = rr_ptr_q;
    perf_stalls_d = perf_stalls_q;
    head_ready_s  = '0;
    if (bus.wb_valid && (bus.wb_rd != '0)) begin
      sb_d[sb_idx(32'(bus.wb_wid), bus.wb_rd)] = 1'b0;
    end else begin
    end
    if (free_s) begin
      if (any_elig_s) begin
        head_ready_s  = grant_s;
        issue_valid_d = 1'b1;
        issue_wid_d   = grant_idx_s;
        rr_ptr_d      = next_ptr_s;
        if (grant_wb_s && (grant_rd_s != '0)) begin
          sb_d[sb_idx(32'(grant_idx_s), grant_rd_s)] = 1'b1;
        end else begin
        end
      end else begin
        issue_valid_d = 1'b0;
        if (|bus.head_valid) begin
          perf_stalls_d = perf_stalls_q + 32'd1;
        end else begin
        end
      end
    end else begin
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_q          <= '0;
      issue_valid_q <= 1'b0;
      issue_wid_q   <= '0;
      rr_ptr_q      <= '0;
      perf_stalls_q <= 32'd0;
    end else begin
      sb_q          <= sb_d;
      issue_valid_q <= issue_valid_d;
      issue_wid_q   <= issue_wid_d;
      rr_ptr_q      <= rr_ptr_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  assign bus.head_ready  = reset ? '0 : head_ready_s;
  assign bus.issue_valid = issue_valid_q;
  assign bus.issue_wid   = issue_wid_q;
  assign bus.perf_stalls = perf_stalls_q;

endmodule

// File: tb/tb_vx_issue_sched.sv
// Directed bench for vx_issue_sched (4 warps, 64 registers).
module tb_vx_issue_sched;
  localparam int NW = 4;
  localparam int NR = 64;
  localparam int RB = 6;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  vx_issue_sched_if #(.NUM_WARPS(NW), .NUM_REGS(NR)) bus ();

  vx_issue_sched #(.NUM_WARPS(NW), .NUM_REGS(NR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_head(input int w, input logic v, input logic [5:0] rd,
                          input logic wb, input logic [5:0] rs1, input logic [2:0] use_rs);
    bus.head_valid[w]         = v;
    bus.head_rd[w*RB +: RB]   = rd;
    bus.head_wb[w]            = wb;
    bus.head_rs1[w*RB +: RB]  = rs1;
    bus.head_rs2[w*RB +: RB]  = 6'd0;
    bus.head_rs3[w*RB +: RB]  = 6'd0;
    bus.head_use_rs[w*3 +: 3] = use_rs;
  endtask

  task automatic clear_heads();
    bus.head_valid  = '0;
    bus.head_rd     = '0;
    bus.head_wb     = '0;
    bus.head_rs1    = '0;
    bus.head_rs2    = '0;
    bus.head_rs3    = '0;
    bus.head_use_rs = '0;
  endtask

  task automatic test_reset();
    clear_heads();
    bus.issue_ready = 1'b1;
    bus.wb_valid    = 1'b0;
    bus.wb_wid      = 2'd0;
    bus.wb_rd       = 6'd0;
    reset           = 1'b1;
    bus.head_valid  = 4'b1111;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (bus.issue_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bus.issue_valid); end
    n_cmp++; if (bus.issue_wid !== 2'd0) begin n_bad++; $display("FAIL reset_wid: got %0d want 0", bus.issue_wid); end
    n_cmp++; if (bus.perf_stalls !== 32'd0) begin n_bad++; $display("FAIL reset_perf: got %0d want 0", bus.perf_stalls); end
    n_cmp++; if (bus.head_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_hr: got %b want 0000", bus.head_ready); end
    @(negedge clk);
    reset = 1'b0;
    clear_heads();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_hr;
    logic [1:0] exp_wid;
    for (int w = 0; w < NW; w++) set_head(w, 1'b1, 6'd0, 1'b0, 6'd0, 3'b000);
    for (int i = 0; i < 5; i++) begin
      #1;
      exp_hr = 4'(1 << (i % 4));
      n_cmp++; if (bus.head_ready !== exp_hr) begin n_bad++; $display("FAIL rr_hr%0d: got %b want %b", i, bus.head_ready, exp_hr); end
      if (i > 0) begin
        exp_wid = 2'((i - 1) % 4);
        n_cmp++; if (bus.issue_valid !== 1'b1 || bus.issue_wid !== exp_wid) begin n_bad++; $display("FAIL rr_wid%0d: got v=%b w=%0d want v=1 w=%0d", i, bus.issue_valid, bus.issue_wid, exp_wid); end
      end
      @(negedge clk);
    end
    #1;
    n_cmp++; if (bus.issue_valid !== 1'b1 || bus.issue_wid !== 2'd0) begin n_bad++; $display("FAIL rr_wid5: got v=%b w=%0d want v=1 w=0", bus.issue_valid, bus.issue_wid); end
    n_cmp++; if (bus.perf_stalls !== 32'd0) begin n_bad++; $display("FAIL rr_perf: got %0d want 0", bus.perf_stalls); end
    clear_heads();
  endtask

  task automatic test_raw_stall();
    @(negedge clk);
    set_head(1, 1'b1, 6'd5, 1'b1, 6'd0, 3'b000);
    #1;
    n_cmp++; if (bus.head_ready !== 4'b0010) begin n_bad++; $display("FAIL raw_hr_first: got %b want 0010", bus.head_ready); end
    @(negedge clk); #1;
    n_cmp++; if (bus.issue_valid !== 1'b1 || bus.issue_wid !== 2'd1) begin n_bad++; $display("FAIL raw_wid_first: got v=%b w=%0d want v=1 w=1", bus.issue_valid, bus.issue_wid); end
    set_head(1, 1'b1, 6'd0, 1'b0, 6'd5, 3'b001);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk); #1;
      n_cmp++; if (bus.head_ready !== 4'b0000) begin n_bad++; $display("FAIL raw_hr_stall%0d: got %b want 0000", k, bus.head_ready); end
      n_cmp++; if (bus.perf_stalls !== 32'(k)) begin n_bad++; $display("FAIL raw_perf%0d: got %0d want %0d", k, bus.perf_stalls, k); end
      n_cmp++; if (bus.issue_valid !== 1'b0) begin n_bad++; $display("FAIL raw_valid%0d: got %b want 0", k, bus.issue_valid); end
    end
    bus.wb_valid = 1'b1;
    bus.wb_wid   = 2'd1;
    bus.wb_rd    = 6'd5;
    #1;
    n_cmp++; if (bus.head_ready !== 4'b0000) begin n_bad++; $display("FAIL raw_hr_wbcycle: got %b want 0000", bus.head_ready); end
    @(negedge clk);
    bus.wb_valid = 1'b0;
    #1;
    n_cmp++; if (bus.head_ready !== 4'b0010) begin n_bad++; $display("FAIL raw_hr_after_wb: got %b want 0010", bus.head_ready); end
    n_cmp++; if (bus.perf_stalls !== 32'd3) begin n_bad++; $display("FAIL raw_perf3: got %0d want 3", bus.perf_stalls); end
    @(negedge clk); #1;
    n_cmp++; if (bus.issue_valid !== 1'b1 || bus.issue_wid !== 2'd1) begin n_bad++; $display("FAIL raw_wid_second: got v=%b w=%0d want v=1 w=1", bus.issue_valid, bus.issue_wid); end
    clear_heads();
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    set_head(0, 1'b1, 6'd0, 1'b0, 6'd0, 3'b000);
    set_head(3, 1'b1, 6'd0, 1'b0, 6'd0, 3'b000);
    #1;
    n_cmp++; if (bus.head_ready !== 4'b1000) begin n_bad++; $display("FAIL bp_hr_first: got %b want 1000", bus.head_ready); end
    @(negedge clk);
    bus.issue_ready = 1'b0;
    #1;
    n_cmp++; if (bus.issue_valid !== 1'b1 || bus.issue_wid !== 2'd3) begin n_bad++; $display("FAIL bp_wid_first: got v=%b w=%0d want v=1 w=3", bus.issue_valid, bus.issue_wid); end
    n_cmp++; if (bus.head_ready !== 4'b0000) begin n_bad++; $display("FAIL bp_hr_block0: got %b want 0000", bus.head_ready); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      n_cmp++; if (bus.head_ready !== 4'b0000) begin n_bad++; $display("FAIL bp_hr_hold%0d: got %b want 0000", k, bus.head_ready); end
      n_cmp++; if (bus.issue_valid !== 1'b1 || bus.issue_wid !== 2'd3) begin n_bad++; $display("FAIL bp_wid_hold%0d: got v=%b w=%0d want v=1 w=3", k, bus.issue_valid, bus.issue_wid); end
    end
    bus.issue_ready = 1'b1;
    #1;
    n_cmp++; if (bus.head_ready !== 4'b0001) begin n_bad++; $display("FAIL bp_hr_resume: got %b want 0001", bus.head_ready); end
    @(negedge clk); #1;
    n_cmp++; if (bus.issue_wid !== 2'd0 || bus.head_ready !== 4'b1000) begin n_bad++; $display("FAIL bp_rot1: got w=%0d hr=%b want w=0 hr=1000", bus.issue_wid, bus.head_ready); end
    @(negedge clk); #1;
    n_cmp++; if (bus.issue_wid !== 2'd3 || bus.perf_stalls !== 32'd3) begin n_bad++; $display("FAIL bp_rot2: got w=%0d perf=%0d want w=3 perf=3", bus.issue_wid, bus.perf_stalls); end
    clear_heads();
  endtask

  task automatic test_rd_zero();
    @(negedge clk);
    set_head(2, 1'b1, 6'd0, 1'b1, 6'd0, 3'b001);
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++; if (bus.head_ready !== 4'b0100) begin n_bad++; $display("FAIL rd0_hr%0d: got %b want 0100", k, bus.head_ready); end
      @(negedge clk);
    end
    #1;
    n_cmp++; if (bus.issue_valid !== 1'b1 || bus.issue_wid !== 2'd2) begin n_bad++; $display("FAIL rd0_wid: got v=%b w=%0d want v=1 w=2", bus.issue_valid, bus.issue_wid); end
    n_cmp++; if (bus.perf_stalls !== 32'd3) begin n_bad++; $display("FAIL rd0_perf: got %0d want 3", bus.perf_stalls); end
    clear_heads();
  endtask

  task automatic test_waw();
    @(negedge clk);
    set_head(0, 1'b1, 6'd7, 1'b1, 6'd0, 3'b000);
    #1;
    n_cmp++; if (bus.head_ready !== 4'b0001) begin n_bad++; $display("FAIL waw_hr_first: got %b want 0001", bus.head_ready); end
    @(negedge clk); #1;
    n_cmp++; if (bus.issue_valid !== 1'b1 || bus.issue_wid !== 2'd0) begin n_bad++; $display("FAIL waw_wid_first: got v=%b w=%0d want v=1 w=0", bus.issue_valid, bus.issue_wid); end
    n_cmp++; if (bus.head_ready !== 4'b0000) begin n_bad++; $display("FAIL waw_hr_block: got %b want 0000", bus.head_ready); end
    @(negedge clk); #1;
    n_cmp++; if (bus.head_ready !== 4'b0000 || bus.perf_stalls !== 32'd4) begin n_bad++; $display("FAIL waw_stall: got hr=%b perf=%0d want hr=0000 perf=4", bus.head_ready, bus.perf_stalls); end
    bus.wb_valid = 1'b1;
    bus.wb_wid   = 2'd0;
    bus.wb_rd    = 6'd7;
    #1;
    n_cmp++; if (bus.head_ready !== 4'b0000) begin n_bad++; $display("FAIL waw_hr_wbcycle: got %b want 0000", bus.head_ready); end
    @(negedge clk);
    bus.wb_valid = 1'b0;
    #1;
    n_cmp++; if (bus.head_ready !== 4'b0001 || bus.perf_stalls !== 32'd5) begin n_bad++; $display("FAIL waw_release: got hr=%b perf=%0d want hr=0001 perf=5", bus.head_ready, bus.perf_stalls); end
    @(negedge clk); #1;
    n_cmp++; if (bus.issue_valid !== 1'b1 || bus.issue_wid !== 2'd0) begin n_bad++; $display("FAIL waw_wid_second: got v=%b w=%0d want v=1 w=0", bus.issue_valid, bus.issue_wid); end
    clear_heads();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    set_head(1, 1'b1, 6'd10, 1'b1, 6'd0, 3'b000);
    set_head(2, 1'b1, 6'd11, 1'b1, 6'd0, 3'b000);
    set_head(3, 1'b1, 6'd12, 1'b1, 6'd0, 3'b000);
    #1;
    n_cmp++; if (bus.head_ready !== 4'b0010) begin n_bad++; $display("FAIL mid_hr1: got %b want 0010", bus.head_ready); end
    @(negedge clk); #1;
    n_cmp++; if (bus.issue_wid !== 2'd1 || bus.head_ready !== 4'b0100) begin n_bad++; $display("FAIL mid_step2: got w=%0d hr=%b want w=1 hr=0100", bus.issue_wid, bus.head_ready); end
    @(negedge clk); #1;
    n_cmp++; if (bus.issue_wid !== 2'd2 || bus.head_ready !== 4'b1000) begin n_bad++; $display("FAIL mid_step3: got w=%0d hr=%b want w=2 hr=1000", bus.issue_wid, bus.head_ready); end
    @(negedge clk);
    bus.issue_ready = 1'b0;
    #1;
    n_cmp++; if (bus.issue_valid !== 1'b1 || bus.issue_wid !== 2'd3) begin n_bad++; $display("FAIL mid_held: got v=%b w=%0d want v=1 w=3", bus.issue_valid, bus.issue_wid); end
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.issue_valid !== 1'b0 || bus.issue_wid !== 2'd0) begin n_bad++; $display("FAIL mid_rst_issue: got v=%b w=%0d want v=0 w=0", bus.issue_valid, bus.issue_wid); end
    n_cmp++; if (bus.perf_stalls !== 32'd0 || bus.head_ready !== 4'b0000) begin n_bad++; $display("FAIL mid_rst_misc: got perf=%0d hr=%b want perf=0 hr=0000", bus.perf_stalls, bus.head_ready); end
    @(negedge clk);
    set_head(0, 1'b1, 6'd0, 1'b0, 6'd0, 3'b000);
    reset           = 1'b0;
    bus.issue_ready = 1'b1;
    #1;
    n_cmp++; if (bus.head_ready !== 4'b0001) begin n_bad++; $display("FAIL mid_first_grant: got %b want 0001", bus.head_ready); end
    @(negedge clk); #1;
    n_cmp++; if (bus.issue_wid !== 2'd0 || bus.head_ready !== 4'b0010) begin n_bad++; $display("FAIL mid_sb_clear1: got w=%0d hr=%b want w=0 hr=0010", bus.issue_wid, bus.head_ready); end
    @(negedge clk); #1;
    n_cmp++; if (bus.issue_wid !== 2'd1 || bus.head_ready !== 4'b0100) begin n_bad++; $display("FAIL mid_sb_clear2: got w=%0d hr=%b want w=1 hr=0100", bus.issue_wid, bus.head_ready); end
    @(negedge clk); #1;
    n_cmp++; if (bus.issue_wid !== 2'd2 || bus.head_ready !== 4'b1000) begin n_bad++; $display("FAIL mid_sb_clear3: got w=%0d hr=%b want w=2 hr=1000", bus.issue_wid, bus.head_ready); end
    clear_heads();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    test_reset();
    test_round_robin();
    test_raw_stall();
    test_backpressure();
    test_rd_zero();
    test_waw();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
